// File: rtl/alu_pkg.sv
// Shared definitions for the sequenced ALU: ctrl codes, funct3 codes,
// FSM state type and the funct3/funct7 decoder.
package alu_pkg;

   localparam logic [3:0] ALU_AND     = 4'b0000;
   localparam logic [3:0] ALU_OR      = 4'b0001;
   localparam logic [3:0] ALU_ADD     = 4'b0010;
   localparam logic [3:0] ALU_SUB     = 4'b0110;
   localparam logic [3:0] ALU_SLT     = 4'b0111;
   localparam logic [3:0] ALU_NOR     = 4'b1100;
   localparam logic [3:0] ALU_NAND    = 4'b1101;
   localparam logic [3:0] ALU_ILLEGAL = 4'b1111;

   localparam logic [2:0] F3_ADD = 3'b000;
   localparam logic [2:0] F3_SLT = 3'b010;
   localparam logic [2:0] F3_OR  = 3'b110;
   localparam logic [2:0] F3_AND = 3'b111;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_RESP = 2'b10
   } state_e;

   // SUB only exists as an R-type; ADDI ignores funct7[5] since that bit
   // belongs to the immediate.
   function automatic logic [3:0] decode_ctrl(input logic [2:0] funct3,
                                              input logic       funct7b5,
                                              input logic       is_imm);
      logic [3:0] ctrl;
      case (funct3)
         F3_ADD:  ctrl = (funct7b5 && !is_imm) ? ALU_SUB : ALU_ADD;
         F3_AND:  ctrl = ALU_AND;
         F3_OR:   ctrl = ALU_OR;
         F3_SLT:  ctrl = ALU_SLT;
         default: ctrl = ALU_ILLEGAL;
      endcase
      return ctrl;
   endfunction

endpackage

// File: rtl/alu_seq_alu.sv
// Combinational 32-bit ALU. Unknown ctrl codes produce zero.
// Flags: N/Z follow the result; C/V are only meaningful for ADD/SUB
// (C is the adder carry-out, i.e. "no borrow" for SUB).
module alu_seq_alu
   import alu_pkg::*;
(
   input  logic [3:0]  ctrl_i,
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] result_o,
   output logic [3:0]  nzcv_o
);

   logic        sub;
   logic        arith;
   logic        ovf;
   logic [31:0] b_x;
   logic [32:0] sum;

   // shared adder for ADD/SUB/SLT, then result mux and flag generation
   always_comb begin
      sub   = (ctrl_i == ALU_SUB) || (ctrl_i == ALU_SLT);
      arith = (ctrl_i == ALU_ADD) || (ctrl_i == ALU_SUB);
      b_x   = sub ? ~b_i : b_i;
      sum   = {1'b0, a_i} + {1'b0, b_x} + {32'd0, sub};
      ovf   = (a_i[31] == b_x[31]) && (sum[31] != a_i[31]);
      case (ctrl_i)
         ALU_AND:  result_o = a_i & b_i;
         ALU_OR:   result_o = a_i | b_i;
         ALU_ADD:  result_o = sum[31:0];
         ALU_SUB:  result_o = sum[31:0];
         ALU_SLT:  result_o = {31'd0, sum[31] ^ ovf};
         ALU_NOR:  result_o = ~(a_i | b_i);
         ALU_NAND: result_o = ~(a_i & b_i);
         default:  result_o = 32'd0;
      endcase
      nzcv_o = {result_o[31], (result_o == 32'd0), arith & sum[32], arith & ovf};
   end

endmodule

// File: rtl/alu_seq.sv
// Sequenced ALU: accept a request, evaluate in one EXEC cycle, then hold the
// registered result until the consumer takes it.
// Optional: define ALU_SEQ_FLAGS_EN to add the registered NZCV_o flag port.
//
// state | meaning
// IDLE  | ready for a request; operands/ctrl loaded on accept
// EXEC  | ALU evaluates registered operands; result captured
// RESP  | result valid, held until rsp_ready_i
module alu_seq
   import alu_pkg::*;
(
   input  logic        clk_i,
   input  logic        rst_n_i,
   input  logic        req_valid_i,
   output logic        req_ready_o,
   input  logic [2:0]  funct3_i,
   input  logic        funct7b5_i,
   input  logic        is_imm_i,
   input  logic [31:0] srcA_i,
   input  logic [31:0] srcB_i,
   input  logic        flush_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
`ifdef ALU_SEQ_FLAGS_EN
   output logic [3:0]  NZCV_o,
`endif
   output logic [31:0] result_o,
   output logic        illegal_o
);

   state_e      state_q, state_d;
   logic [31:0] src_a_q, src_b_q;
   logic [3:0]  ctrl_q;
   logic [31:0] result_q;
   logic        illegal_q;
   logic        accept;
   logic [31:0] alu_result;
   logic [3:0]  alu_nzcv;

   alu_seq_alu u_alu (
      .ctrl_i   (ctrl_q),
      .a_i      (src_a_q),
      .b_i      (src_b_q),
      .result_o (alu_result),
      .nzcv_o   (alu_nzcv)
   );

   // next-state and handshake outputs; flush overrides every transition
   always_comb begin
      state_d     = state_q;
      req_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      accept      = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_ready_o = rst_n_i;
            if (req_valid_i && rst_n_i && !flush_i) begin
               accept  = 1'b1;
               state_d = ST_EXEC;
            end
         end
         ST_EXEC: state_d = ST_RESP;
         ST_RESP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (flush_i) state_d = ST_IDLE;
   end

   // state register
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) state_q <= ST_IDLE;
      else          state_q <= state_d;
   end

   // operand/ctrl capture, only on an accepted request
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         src_a_q <= 32'd0;
         src_b_q <= 32'd0;
         ctrl_q  <= 4'd0;
      end else if (accept) begin
         src_a_q <= srcA_i;
         src_b_q <= srcB_i;
         ctrl_q  <= decode_ctrl(funct3_i, funct7b5_i, is_imm_i);
      end
   end

   // result capture at the end of EXEC; a flushed EXEC leaves the old result
   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         result_q  <= 32'd0;
         illegal_q <= 1'b0;
      end else if (state_q == ST_EXEC && !flush_i) begin
         result_q  <= alu_result;
         illegal_q <= (ctrl_q == ALU_ILLEGAL);
      end
   end

   assign result_o  = result_q;
   assign illegal_o = illegal_q;

`ifdef ALU_SEQ_FLAGS_EN
   logic [3:0] nzcv_q;

   // flag capture alongside the result
   always_ff @(posedge clk_i) begin
      if (!rst_n_i)                            nzcv_q <= 4'd0;
      else if (state_q == ST_EXEC && !flush_i) nzcv_q <= alu_nzcv;
   end

   assign NZCV_o = nzcv_q;
`else
   logic unused_nzcv;
   assign unused_nzcv = ^alu_nzcv;
`endif

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq. Inputs change and outputs are sampled on the
// falling edge. Flag checks are compiled in with ALU_SEQ_FLAGS_EN.
module tb_alu_seq;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid;
   logic        req_ready;
   logic [2:0]  funct3;
   logic        funct7b5;
   logic        is_imm;
   logic [31:0] src_a, src_b;
   logic        flush;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] result;
   logic        illegal;
`ifdef ALU_SEQ_FLAGS_EN
   logic [3:0]  nzcv;
`endif

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   alu_seq dut (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .req_valid_i (req_valid),
      .req_ready_o (req_ready),
      .funct3_i    (funct3),
      .funct7b5_i  (funct7b5),
      .is_imm_i    (is_imm),
      .srcA_i      (src_a),
      .srcB_i      (src_b),
      .flush_i     (flush),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
`ifdef ALU_SEQ_FLAGS_EN
      .NZCV_o      (nzcv),
`endif
      .result_o    (result),
      .illegal_o   (illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // present a request at a falling edge; returns one cycle later (state EXEC)
   // after scrambling the inputs so frozen operand registers are exercised
   task automatic issue(input logic [2:0] f3, input logic f7, input logic imm,
                        input logic [31:0] a, input logic [31:0] b);
      funct3    = f3;
      funct7b5  = f7;
      is_imm    = imm;
      src_a     = a;
      src_b     = b;
      req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      funct3    = 3'b001;
      funct7b5  = ~f7;
      src_a     = 32'hDEAD_BEEF;
      src_b     = 32'h1234_5678;
   endtask

   // full transaction with the consumer always ready
   task automatic txn(input string name, input logic [2:0] f3, input logic f7,
                      input logic imm, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] exp_res, input logic exp_ill,
                      input logic [3:0] exp_nzcv);
      rsp_ready = 1'b1;
      issue(f3, f7, imm, a, b);
      chk({name, "_exec_ready"}, {31'd0, req_ready}, 32'd0);
      chk({name, "_exec_valid"}, {31'd0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk({name, "_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({name, "_result"}, result, exp_res);
      chk({name, "_illegal"}, {31'd0, illegal}, {31'd0, exp_ill});
`ifdef ALU_SEQ_FLAGS_EN
      chk({name, "_nzcv"}, {28'd0, nzcv}, {28'd0, exp_nzcv});
`else
      if (exp_nzcv === 4'bxxxx) $display("unreachable");
`endif
      @(negedge clk);
      chk({name, "_done_valid"}, {31'd0, rsp_valid}, 32'd0);
      chk({name, "_done_ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; funct3 = 3'd0; funct7b5 = 1'b0;
      is_imm = 1'b0; src_a = 32'd0; src_b = 32'd0; flush = 1'b0; rsp_ready = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_ready", {31'd0, req_ready}, 32'd0);
      chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rst_result", result, 32'd0);
      chk("rst_illegal", {31'd0, illegal}, 32'd0);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

      txn("add",   3'b000, 1'b0, 1'b0, 32'd5, 32'd7, 32'd12, 1'b0, 4'b0000);
      txn("sub",   3'b000, 1'b1, 1'b0, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0, 4'b1000);
      txn("addi",  3'b000, 1'b1, 1'b1, 32'd3, 32'd5, 32'd8, 1'b0, 4'b0000);
      txn("slt_t", 3'b010, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 4'b0000);
      txn("slt_f", 3'b010, 1'b0, 1'b0, 32'd5, 32'd3, 32'd0, 1'b0, 4'b0100);
      txn("illeg", 3'b001, 1'b0, 1'b0, 32'd9, 32'd9, 32'd0, 1'b1, 4'b0100);
      txn("carry", 3'b000, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0, 4'b0110);
      txn("ovf",   3'b000, 1'b0, 1'b0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b0, 4'b1001);

      // backpressure: result held, no new request taken, even at handshake
      rsp_ready = 1'b0;
      issue(3'b111, 1'b0, 1'b0, 32'hF0F0_F0F0, 32'hFF00_FF00);
      req_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("bp_valid", {31'd0, rsp_valid}, 32'd1);
         chk("bp_result", result, 32'hF000_F000);
         chk("bp_ready", {31'd0, req_ready}, 32'd0);
      end
`ifdef ALU_SEQ_FLAGS_EN
      chk("bp_nzcv", {28'd0, nzcv}, 32'h8);
`endif
      rsp_ready = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);
      chk("bp_idle_ready", {31'd0, req_ready}, 32'd1);

      // flush in EXEC
      issue(3'b110, 1'b0, 1'b0, 32'd7, 32'd8);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_exec_valid", {31'd0, rsp_valid}, 32'd0);
      chk("fl_exec_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      chk("fl_exec_valid2", {31'd0, rsp_valid}, 32'd0);
      txn("or", 3'b110, 1'b0, 1'b0, 32'd1, 32'd2, 32'd3, 1'b0, 4'b0000);

      // flush in RESP beats the response handshake
      issue(3'b000, 1'b0, 1'b0, 32'd1, 32'd1);
      @(negedge clk);
      chk("fl_resp_pre", {31'd0, rsp_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl_resp_valid", {31'd0, rsp_valid}, 32'd0);
      chk("fl_resp_ready", {31'd0, req_ready}, 32'd1);

      // flush in IDLE drops a same-cycle request
      funct3 = 3'b000; src_a = 32'd1; src_b = 32'd1;
      req_valid = 1'b1; flush = 1'b1;
      @(negedge clk);
      req_valid = 1'b0; flush = 1'b0;
      chk("fl_idle_ready", {31'd0, req_ready}, 32'd1);
      @(negedge clk);
      chk("fl_idle_valid", {31'd0, rsp_valid}, 32'd0);

      // reset while in RESP clears everything
      rsp_ready = 1'b0;
      issue(3'b000, 1'b0, 1'b0, 32'd5, 32'd7);
      @(negedge clk);
      chk("rr_pre_result", result, 32'd12);
      rst_n = 1'b0;
      @(negedge clk);
      chk("rr_valid", {31'd0, rsp_valid}, 32'd0);
      chk("rr_result", result, 32'd0);
      chk("rr_illegal", {31'd0, illegal}, 32'd0);
      chk("rr_ready", {31'd0, req_ready}, 32'd0);
`ifdef ALU_SEQ_FLAGS_EN
      chk("rr_nzcv", {28'd0, nzcv}, 32'd0);
`endif
      rst_n = 1'b1;
      @(negedge clk);
      chk("rr_ready_after", {31'd0, req_ready}, 32'd1);
      txn("add2", 3'b000, 1'b0, 1'b0, 32'd100, 32'd23, 32'd123, 1'b0, 4'b0000);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
